imm_extend_pipe: RTL and testbench
==================================

// Module: imm_extend_pipe
// PURPOSE
//  Parametrised, pipelined immediate-extension unit for the decode stage.
//  Successor to the fixed 16->32 sign extender: adds selectable extension modes,
//  a valid/ready handshake with a one-entry skid buffer, a tag sideband and a flush.
//  Sits between instruction decode and the ID/EX register; feeds ALU operand B
//  and the branch-target adder.
// PARAMETERS
//  IN_W   16  immediate field width
//  OUT_W  32  extended result width; legal only if OUT_W >= IN_W+2
//  TAG_W  5   sideband tag width (e.g. destination register); passed through unchanged
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  reset      in   1       synchronous, active-high
//  flush      in   1       discard all held and in-flight data (branch/exception)
//  in_valid   in   1       input word present
//  in_ready   out  1       unit can accept; transfer when in_valid && in_ready
//  in_imm     in   IN_W    raw immediate
//  in_mode    in   2       00 SIGN, 01 ZERO, 10 UPPER, 11 BRANCH
//  in_tag     in   TAG_W   sideband
//  out_valid  out  1       result present
//  out_ready  in   1       consumer accepts; transfer when out_valid && out_ready
//  out_data   out  OUT_W   extended result
//  out_tag    out  TAG_W   tag of out_data
// BEHAVIOUR
//  Reset: clocked with reset=1 -> out_valid=0, out_data=0, out_tag=0, skid empty,
//   in_ready=1 from the next cycle. Reset overrides flush and any handshake.
//  Modes (computed combinationally on input, registered on accept):
//   SIGN   : {{(OUT_W-IN_W){imm[IN_W-1]}}, imm}
//   ZERO   : {{(OUT_W-IN_W){1'b0}}, imm}
//   UPPER  : imm << (OUT_W-IN_W), low bits zero (LUI)
//   BRANCH : SIGN result << 2, top 2 bits discarded (word offset to byte offset)
//  Latency: accepted word appears on out_data exactly 1 cycle later if output
//   stage was empty or being drained that cycle.
//  Storage: output register + one-entry skid register; in_ready = !skid_valid
//   (registered, no combinational path from out_ready to in_ready).
//  Accept rules per cycle (no flush):
//   - output empty or out_ready=1: skid content (if any) moves to output,
//     else accepted input moves to output; if skid drained and input also
//     accepted, input goes to output after skid word (skid takes it).
//   - output full and out_ready=0: accepted input goes to skid; in_ready=0 next.
//   - order of words is always preserved; no word dropped or duplicated.
//  Output holds out_data/out_tag stable while out_valid=1 and out_ready=0.
//  Flush (reset=0, flush=1): next cycle out_valid=0, skid empty, in_ready=1;
//   an input handshaking in the flush cycle is discarded; out_data keeps last
//   value (don't-care when out_valid=0). Back-to-back flushes legal.
//  in_mode/in_imm/in_tag sampled only on accept; X when in_valid=0 is harmless.
//  Simultaneous out transfer and in accept with empty skid: full throughput,
//   1 word/cycle sustained.
// TESTING
//  T1 modes, IN_W=16 OUT_W=32, out_ready=1: imm=0x8000 SIGN->0xFFFF8000,
//     ZERO->0x00008000, UPPER imm=0x1234->0x12340000, BRANCH imm=0xFFFF->0xFFFFFFFC,
//     each exactly 1 cycle after accept, tag echoed.
//  T2 streaming: in_valid=1 for 8 words, out_ready=1 -> 8 results on 8 consecutive
//     cycles, in_ready never deasserts.
//  T3 backpressure: out_ready=0 for 3 cycles mid-stream -> one extra word accepted
//     into skid, in_ready=0 next cycle, out_data stable; on release all words
//     emerge in order, none lost.
//  T4 flush with output and skid full and in_valid=1 -> next cycle out_valid=0,
//     in_ready=1; flushed words and the flush-cycle input never appear.
//  T5 reset mid-stall (skid full) -> next cycle out_valid=0, out_data=0, out_tag=0,
//     in_ready=1; reset asserted together with flush behaves as reset.
//  T6 random valid/ready/mode/flush vs reference model for 10k cycles, checking
//     order, values and stability under stall.

Source files
------------

// File: rtl/imm_extend_pipe_if.sv
// Decode-side stream bundle for the immediate extender: input word (imm/mode/tag)
// and output result (data/tag), each with its own valid/ready pair.
interface imm_extend_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  // Producer/consumer side (decode + ID/EX register)
  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  // Extension unit side
  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: SIGN/ZERO/UPPER/BRANCH modes, registered output
// stage backed by a one-entry skid register, tag sideband and flush.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  imm_extend_pipe_if.slave  bus
);

  localparam logic [1:0] MODE_SIGN   = 2'b00;
  localparam logic [1:0] MODE_ZERO   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  if (OUT_W < IN_W + 2) begin : g_width_check
    $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
  end

  function automatic logic [OUT_W-1:0] f_extend(input logic [IN_W-1:0] imm,
                                                 input logic [1:0]      mode);
    logic [OUT_W-1:0] sext;
    sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    case (mode)
      MODE_SIGN:   f_extend = sext;
      MODE_ZERO:   f_extend = {{(OUT_W-IN_W){1'b0}}, imm};
      MODE_UPPER:  f_extend = {imm, {(OUT_W-IN_W){1'b0}}};
      MODE_BRANCH: f_extend = {sext[OUT_W-3:0], 2'b00};
      default:     f_extend = {OUT_W{1'b0}};
    endcase
  endfunction

  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_data;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_skid_valid;
  logic [OUT_W-1:0] r_skid_data;
  logic [TAG_W-1:0] r_skid_tag;

  logic [OUT_W-1:0] w_ext;
  logic             w_accept;
  logic             w_drain;

  // Extension result and per-cycle transfer conditions
  always_comb begin
    w_ext    = f_extend(bus.in_imm, bus.in_mode);
    w_accept = bus.in_valid && !r_skid_valid;
    w_drain  = !r_out_valid || bus.out_ready;
  end

  // Output stage and skid: the skid word always leaves before any new input,
  // and in_ready is derived from the skid flag so out_ready never reaches it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= {OUT_W{1'b0}};
      r_out_tag    <= {TAG_W{1'b0}};
      r_skid_valid <= 1'b0;
      r_skid_data  <= {OUT_W{1'b0}};
      r_skid_tag   <= {TAG_W{1'b0}};
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_drain) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_out_tag    <= r_skid_tag;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_ext;
        r_out_tag   <= bus.in_tag;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= w_ext;
      r_skid_tag   <= bus.in_tag;
    end else begin
      r_skid_valid <= r_skid_valid;
    end
  end

  assign bus.in_ready  = !r_skid_valid;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_tag   = r_out_tag;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed + random bench for imm_extend_pipe with a queue scoreboard that tracks
// every word held by the unit, its values, order and stall stability.
module tb_imm_extend_pipe;
  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  imm_extend_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) bus ();

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [TAG_W+OUT_W-1:0] sb[$];
  bit               hold_pending = 1'b0;
  logic [OUT_W-1:0] hold_data;
  logic [TAG_W-1:0] hold_tag;
  bit               rst_seen = 1'b0;

  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    logic signed [31:0] s;
    s = 32'($signed(imm));
    case (mode)
      2'd0:    return s;
      2'd1:    return {16'h0000, imm};
      2'd2:    return {imm, 16'h0000};
      2'd3:    return s <<< 2;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard step at the negative edge: occupancy, stability, data, then model update
  task automatic sample();
    logic [TAG_W+OUT_W-1:0] e;
    chk("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
    chk("in_ready", 64'(bus.in_ready), 64'(sb.size() < 2));
    if (hold_pending) begin
      chk("hold_data", 64'(bus.out_data), 64'(hold_data));
      chk("hold_tag", 64'(bus.out_tag), 64'(hold_tag));
    end
    if (rst_seen) begin
      chk("rst_data", 64'(bus.out_data), 64'h0);
      chk("rst_tag", 64'(bus.out_tag), 64'h0);
    end
    hold_pending = 1'b0;
    rst_seen     = 1'b0;
    if (reset) begin
      sb.delete();
      rst_seen = 1'b1;
    end else begin
      if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("data", 64'(bus.out_data), 64'(e[OUT_W-1:0]));
        chk("tag", 64'(bus.out_tag), 64'(e[TAG_W+OUT_W-1:OUT_W]));
      end
      if (bus.out_valid && !bus.out_ready && !flush) begin
        hold_pending = 1'b1;
        hold_data    = bus.out_data;
        hold_tag     = bus.out_tag;
      end
      if (flush) sb.delete();
      else if (bus.in_valid && bus.in_ready)
        sb.push_back({bus.in_tag, ref_ext(bus.in_imm, bus.in_mode)});
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                       input logic [4:0] tag);
    bus.in_valid = v;
    bus.in_imm   = imm;
    bus.in_mode  = mode;
    bus.in_tag   = tag;
  endtask

  logic [15:0] t1_imm[4] = '{16'h8000, 16'h8000, 16'h1234, 16'hFFFF};
  logic [1:0]  t1_mode[4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic [31:0] t1_exp[4] = '{32'hFFFF8000, 32'h00008000, 32'h12340000, 32'hFFFFFFFC};

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_out_valid", 64'(bus.out_valid), 64'h0);
    chk("reset_out_data", 64'(bus.out_data), 64'h0);
    chk("reset_out_tag", 64'(bus.out_tag), 64'h0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'h1);

    // T1: each mode, result one cycle after accept
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, t1_imm[i], t1_mode[i], 5'(i + 3));
      cycle();
      chk("t1_valid", 64'(bus.out_valid), 64'h1);
      chk("t1_data", 64'(bus.out_data), 64'(t1_exp[i]));
      chk("t1_tag", 64'(bus.out_tag), 64'(i + 3));
    end
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    cycle();
    cycle();

    // T2: eight-word stream at full throughput
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'($urandom), 2'($urandom), 5'(i));
      chk("t2_in_ready", 64'(bus.in_ready), 64'h1);
      cycle();
    end
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    cycle();
    cycle();

    // T3: three-cycle stall mid-stream
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'($urandom), 2'($urandom), 5'(i + 8));
      bus.out_ready = !(i >= 2 && i < 5);
      cycle();
      if (i == 2) chk("t3_in_ready_low", 64'(bus.in_ready), 64'h0);
    end
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    bus.out_ready = 1'b1;
    repeat (3) cycle();

    // T4: flush with output+skid full, then with output full and a live handshake
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h1111, 2'd0, 5'd1);
    cycle();
    drive(1'b1, 16'h2222, 2'd1, 5'd2);
    cycle();
    chk("t4_skid_full", 64'(bus.in_ready), 64'h0);
    drive(1'b1, 16'h3333, 2'd2, 5'd3);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("t4_flush_valid", 64'(bus.out_valid), 64'h0);
    chk("t4_flush_ready", 64'(bus.in_ready), 64'h1);
    drive(1'b1, 16'h4444, 2'd3, 5'd4);
    cycle();
    drive(1'b1, 16'h5555, 2'd0, 5'd5);
    flush = 1'b1;
    cycle();
    cycle();
    flush = 1'b0;
    chk("t4_flush2_valid", 64'(bus.out_valid), 64'h0);
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    bus.out_ready = 1'b1;
    repeat (3) cycle();

    // T5: reset while stalled with skid full, then reset together with flush
    for (int k = 0; k < 2; k++) begin
      bus.out_ready = 1'b0;
      drive(1'b1, 16'hABCD, 2'd0, 5'd7);
      cycle();
      drive(1'b1, 16'h1357, 2'd3, 5'd9);
      cycle();
      reset = 1'b1;
      flush = 1'(k);
      cycle();
      reset = 1'b0;
      flush = 1'b0;
      chk("t5_valid", 64'(bus.out_valid), 64'h0);
      chk("t5_data", 64'(bus.out_data), 64'h0);
      chk("t5_tag", 64'(bus.out_tag), 64'h0);
      chk("t5_in_ready", 64'(bus.in_ready), 64'h1);
      drive(1'b0, 16'h0, 2'd0, 5'd0);
      bus.out_ready = 1'b1;
      cycle();
    end

    // T6: random traffic, backpressure and flush
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom), 5'($urandom));
      bus.out_ready = 1'($urandom_range(0, 3) != 0);
      flush = 1'($urandom_range(0, 63) == 0);
      cycle();
    end
    flush = 1'b0;
    drive(1'b0, 16'h0, 2'd0, 5'd0);
    bus.out_ready = 1'b1;
    repeat (4) cycle();
    chk("final_drained", 64'(sb.size()), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
